// File: rtl/mont_exp_pkg.sv
// Shared types and constants for the montgomery_exp arbiter.
package mont_exp_pkg;

    localparam int unsigned EXP_T_WIDTH    = 5;
    localparam int unsigned MAX_WORD_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_RESP
    } state_e;

    // Montgomery radix R = 2**word_width, sized for the widest supported word.
    function automatic logic [MAX_WORD_WIDTH:0] exp_r_value(input int unsigned word_width);
        return (MAX_WORD_WIDTH + 1)'(1) << word_width;
    endfunction

endpackage

// File: rtl/mont_exp_arbiter_if.sv
// Control/operand bus between the arbiter (master) and the montgomery_exp unit (slave).
interface mont_exp_arbiter_if #(
    parameter int unsigned WORD_WIDTH = 32
);
    import mont_exp_pkg::*;

    logic                   exp_reset;
    logic                   exp_enable;
    logic                   exp_done;
    logic [WORD_WIDTH-1:0]  exp_m;
    logic [WORD_WIDTH-1:0]  exp_x;
    logic [WORD_WIDTH-1:0]  exp_e;
    logic [EXP_T_WIDTH-1:0] exp_t;
    logic [WORD_WIDTH:0]    exp_R;
    logic [WORD_WIDTH-1:0]  exp_result;

    modport master (
        output exp_reset, exp_enable, exp_m, exp_x, exp_e, exp_t, exp_R,
        input  exp_done, exp_result
    );

    modport slave (
        input  exp_reset, exp_enable, exp_m, exp_x, exp_e, exp_t, exp_R,
        output exp_done, exp_result
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    id_c
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant_c = '0;
        id_c    = '0;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (en && !found && req[idx]) begin
                grant_c[idx] = 1'b1;
                id_c         = idx;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mont_exp_arbiter.sv
// Round-robin sharing of one montgomery_exp unit between NUM_REQ requesters.
// Optional watchdog abort of hung jobs: define MONT_EXP_ARB_WATCHDOG_EN.
module mont_exp_arbiter
    import mont_exp_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_m,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_e,
    input  logic [NUM_REQ*EXP_T_WIDTH-1:0]  req_t,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [WORD_WIDTH-1:0]           rsp_data,
    output logic                            rsp_err,
    output logic                            busy,
    output logic                            exp_reset,
    output logic                            exp_enable,
    input  logic                            exp_done,
    output logic [WORD_WIDTH-1:0]           exp_m,
    output logic [WORD_WIDTH-1:0]           exp_x,
    output logic [WORD_WIDTH-1:0]           exp_e,
    output logic [EXP_T_WIDTH-1:0]          exp_t,
    output logic [WORD_WIDTH:0]             exp_R,
    input  logic [WORD_WIDTH-1:0]           exp_result
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("mont_exp_arbiter: NUM_REQ must be 2..8");
    end
    if (WORD_WIDTH < 1 || WORD_WIDTH > MAX_WORD_WIDTH) begin : g_bad_width
        $error("mont_exp_arbiter: WORD_WIDTH out of range");
    end
    if (TIMEOUT_CYCLES < 3) begin : g_bad_timeout
        $error("mont_exp_arbiter: TIMEOUT_CYCLES must be at least 3");
    end

    // Per-requester views of the packed operand buses.
    logic [WORD_WIDTH-1:0]  m_arr [NUM_REQ];
    logic [WORD_WIDTH-1:0]  x_arr [NUM_REQ];
    logic [WORD_WIDTH-1:0]  e_arr [NUM_REQ];
    logic [EXP_T_WIDTH-1:0] t_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign m_arr[i] = req_m[i*WORD_WIDTH +: WORD_WIDTH];
        assign x_arr[i] = req_x[i*WORD_WIDTH +: WORD_WIDTH];
        assign e_arr[i] = req_e[i*WORD_WIDTH +: WORD_WIDTH];
        assign t_arr[i] = req_t[i*EXP_T_WIDTH +: EXP_T_WIDTH];
    end

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [WORD_WIDTH-1:0]  exp_m_q, exp_m_d;
    logic [WORD_WIDTH-1:0]  exp_x_q, exp_x_d;
    logic [WORD_WIDTH-1:0]  exp_e_q, exp_e_d;
    logic [EXP_T_WIDTH-1:0] exp_t_q, exp_t_d;
    logic                   exp_reset_q, exp_reset_d;
    logic                   exp_enable_q, exp_enable_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [WORD_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     grant_c;
    logic [ID_W-1:0]        grant_id_c;
    logic                   idle_c;

`ifdef MONT_EXP_ARB_WATCHDOG_EN
    localparam int unsigned           WD_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]       WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0]                  wd_cnt_q, wd_cnt_d;
    logic [WD_W-1:0]                  wd_inc_c;
    logic                             rsp_err_q, rsp_err_d;

    assign wd_inc_c = wd_cnt_q + WD_W'(1);
    assign rsp_err  = rsp_err_q;
`else
    assign rsp_err  = 1'b0;
`endif

    assign idle_c = (state_q == ST_IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (idle_c),
        .grant_c (grant_c),
        .id_c    (grant_id_c)
    );

    // Acceptance is same-cycle, so the grant is exposed unregistered.
    assign req_ready = grant_c;

    // Job sequencing; every registered output is computed from the next state.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        exp_m_d      = exp_m_q;
        exp_x_d      = exp_x_q;
        exp_e_d      = exp_e_q;
        exp_t_d      = exp_t_q;
        exp_reset_d  = 1'b0;
        exp_enable_d = 1'b0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
`ifdef MONT_EXP_ARB_WATCHDOG_EN
        rsp_err_d    = rsp_err_q;
        wd_cnt_d     = wd_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (|grant_c) begin
                    state_d     = ST_LOAD;
                    id_d        = grant_id_c;
                    exp_m_d     = m_arr[grant_id_c];
                    exp_x_d     = x_arr[grant_id_c];
                    exp_e_d     = e_arr[grant_id_c];
                    exp_t_d     = t_arr[grant_id_c];
                    exp_reset_d = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d      = ST_RUN;
                exp_enable_d = 1'b1;
`ifdef MONT_EXP_ARB_WATCHDOG_EN
                wd_cnt_d     = '0;
`endif
            end
            ST_RUN: begin
                if (exp_done) begin
                    state_d            = ST_RESP;
                    rsp_valid_d[id_q]  = 1'b1;
                    rsp_data_d         = exp_result;
`ifdef MONT_EXP_ARB_WATCHDOG_EN
                    rsp_err_d          = 1'b0;
`endif
                end
`ifdef MONT_EXP_ARB_WATCHDOG_EN
                else if (wd_inc_c == WD_LIMIT) begin
                    state_d            = ST_RESP;
                    rsp_valid_d[id_q]  = 1'b1;
                    rsp_data_d         = '0;
                    rsp_err_d          = 1'b1;
                end
`endif
                else begin
                    exp_enable_d = 1'b1;
`ifdef MONT_EXP_ARB_WATCHDOG_EN
                    wd_cnt_d     = wd_inc_c;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            exp_m_q      <= '0;
            exp_x_q      <= '0;
            exp_e_q      <= '0;
            exp_t_q      <= '0;
            exp_reset_q  <= 1'b0;
            exp_enable_q <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
`ifdef MONT_EXP_ARB_WATCHDOG_EN
            rsp_err_q    <= 1'b0;
            wd_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            exp_m_q      <= exp_m_d;
            exp_x_q      <= exp_x_d;
            exp_e_q      <= exp_e_d;
            exp_t_q      <= exp_t_d;
            exp_reset_q  <= exp_reset_d;
            exp_enable_q <= exp_enable_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            busy_q       <= busy_d;
`ifdef MONT_EXP_ARB_WATCHDOG_EN
            rsp_err_q    <= rsp_err_d;
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

    assign exp_m      = exp_m_q;
    assign exp_x      = exp_x_q;
    assign exp_e      = exp_e_q;
    assign exp_t      = exp_t_q;
    assign exp_reset  = exp_reset_q;
    assign exp_enable = exp_enable_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = busy_q;
    assign exp_R      = (WORD_WIDTH + 1)'(exp_r_value(WORD_WIDTH));

endmodule
